// File: rtl/add_pkg.sv
// Shared constants, operand-beat layout and helpers for the add64 accumulate pipeline.
// Optional build macro: ADD64_PIPE_SUB_EN (adds a subtract control bit to every beat).
package add_pkg;

  localparam int unsigned ADD_W = 64;
  localparam int unsigned BLK4  = 4;
  localparam int unsigned BLK16 = 16;

`ifdef ADD64_PIPE_SUB_EN
  localparam int unsigned CTRL_W = 3;  // cin, acc, sub
`else
  localparam int unsigned CTRL_W = 2;  // cin, acc
`endif

  // Operand beat at the default width; the pipeline packs beats of width N in this field order.
  typedef struct packed {
    logic [ADD_W-1:0] a;
    logic [ADD_W-1:0] b;
    logic             cin;
    logic             acc;
`ifdef ADD64_PIPE_SUB_EN
    logic             sub;
`endif
  } beat_t;

  // Event that sets the sticky flag: a carry for adds, a borrow (no carry) for subtracts.
  function automatic logic carry_event(input logic cout, input logic sub);
    return sub ? ~cout : cout;
  endfunction

endpackage

// File: rtl/add64CLA.sv
// Carry-lookahead adder core: 4-bit lookahead blocks, four blocks per 16-bit group,
// group carries chained between 16-bit groups. Width must be a multiple of 16.
module add64CLA
  import add_pkg::*;
#(
  parameter int unsigned Width = ADD_W
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic             cin_i,
  output logic [Width-1:0] sum_o,
  output logic             cout_o
);

  localparam int unsigned NumBlk = Width / BLK4;
  localparam int unsigned NumGrp = Width / BLK16;

  logic [Width-1:0]  p, g, c;
  logic [NumBlk-1:0] bp, bg, cb;
  logic [NumGrp-1:0] gp, gg;
  logic [NumGrp:0]   cg;

  // Propagate/generate tree, then carries resolved top-down from group to block to bit.
  always_comb begin
    p = a_i ^ b_i;
    g = a_i & b_i;

    for (int k = 0; k < int'(NumBlk); k++) begin
      bp[k] = &p[4*k +: 4];
      bg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1]) |
              (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
    end

    for (int j = 0; j < int'(NumGrp); j++) begin
      gp[j] = &bp[4*j +: 4];
      gg[j] = bg[4*j+3] | (bp[4*j+3] & bg[4*j+2]) | (bp[4*j+3] & bp[4*j+2] & bg[4*j+1]) |
              (bp[4*j+3] & bp[4*j+2] & bp[4*j+1] & bg[4*j]);
    end

    cg[0] = cin_i;
    for (int j = 0; j < int'(NumGrp); j++) begin
      cg[j+1] = gg[j] | (gp[j] & cg[j]);
    end

    for (int j = 0; j < int'(NumGrp); j++) begin
      cb[4*j]   = cg[j];
      cb[4*j+1] = bg[4*j] | (bp[4*j] & cg[j]);
      cb[4*j+2] = bg[4*j+1] | (bp[4*j+1] & bg[4*j]) | (bp[4*j+1] & bp[4*j] & cg[j]);
      cb[4*j+3] = bg[4*j+2] | (bp[4*j+2] & bg[4*j+1]) | (bp[4*j+2] & bp[4*j+1] & bg[4*j]) |
                  (bp[4*j+2] & bp[4*j+1] & bp[4*j] & cg[j]);
    end

    for (int k = 0; k < int'(NumBlk); k++) begin
      c[4*k]   = cb[k];
      c[4*k+1] = g[4*k] | (p[4*k] & cb[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & cb[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k]) |
                 (p[4*k+2] & p[4*k+1] & p[4*k] & cb[k]);
    end

    sum_o  = p ^ c;
    cout_o = cg[NumGrp];
  end

endmodule

// File: rtl/add_pipe_slice.sv
// Valid/ready register slice: one entry, full throughput, async active-low reset.
module add_pipe_slice #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [Width-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [Width-1:0] out_data_o
);

  logic             valid_d, valid_q;
  logic [Width-1:0] data_d, data_q;
  logic             load;

  // Accept when empty or when the held entry leaves on the same edge.
  always_comb begin
    in_ready_o = ~valid_q | out_ready_i;
    load       = in_valid_i & in_ready_o;
    valid_d    = valid_q;
    data_d     = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = in_data_i;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Slice register; data is held stable while not loading.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

endmodule

// File: rtl/add64_accum_pipe.sv
// Two-stage handshaked adder with running accumulator and sticky carry flag.
// Stage 1 holds the operand beat; the adder sits between stage 1 and stage 2.
// Optional build macro: ADD64_PIPE_SUB_EN adds in_sub (A_eff - B with borrow tracking).
module add64_accum_pipe
  import add_pkg::*;
#(
  parameter int unsigned N = ADD_W  // multiple of 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic         in_cin,
  input  logic         in_acc,
`ifdef ADD64_PIPE_SUB_EN
  input  logic         in_sub,
`endif
  input  logic         clear,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_sum,
  output logic         out_cout,
  output logic         out_carry_sticky
);

  localparam int unsigned BeatW = 2 * N + CTRL_W;

  logic [BeatW-1:0] in_beat, s1_beat;
  logic             s1_valid, s2_ready, advance;
  logic [N-1:0]     s1_a, s1_b;
  logic             s1_cin, s1_acc, s1_sub;

  logic [N-1:0]     a_eff, b_core, core_sum;
  logic             cin_core, core_cout, carry_evt;

  logic [N-1:0]     acc_d, acc_q;
  logic             sticky_d, sticky_q;

`ifdef ADD64_PIPE_SUB_EN
  assign in_beat = {in_a, in_b, in_cin, in_acc, in_sub};
  assign s1_sub  = s1_beat[0];
`else
  assign in_beat = {in_a, in_b, in_cin, in_acc};
  assign s1_sub  = 1'b0;
`endif

  assign s1_a   = s1_beat[BeatW-1 -: N];
  assign s1_b   = s1_beat[BeatW-N-1 -: N];
  assign s1_cin = s1_beat[CTRL_W-1];
  assign s1_acc = s1_beat[CTRL_W-2];

  add_pipe_slice #(
    .Width(BeatW)
  ) u_s1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_beat),
    .out_valid_o(s1_valid),
    .out_ready_i(s2_ready),
    .out_data_o (s1_beat)
  );

  // Operand select at the stage-1 output so a beat sees the sum of the beat just ahead of it.
  always_comb begin
    a_eff    = s1_acc ? acc_q : s1_a;
    b_core   = s1_b;
    cin_core = s1_cin;
    if (s1_sub) begin
      b_core   = ~s1_b;
      cin_core = 1'b1;
    end
    carry_evt = carry_event(core_cout, s1_sub);
  end

  add64CLA #(
    .Width(N)
  ) u_core (
    .a_i   (a_eff),
    .b_i   (b_core),
    .cin_i (cin_core),
    .sum_o (core_sum),
    .cout_o(core_cout)
  );

  add_pipe_slice #(
    .Width(N + 1)
  ) u_s2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_i (s1_valid),
    .in_ready_o (s2_ready),
    .in_data_i  ({core_sum, core_cout}),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o ({out_sum, out_cout})
  );

  assign advance = s1_valid & s2_ready;

  // Accumulator and sticky follow the beat entering stage 2; clear overrides that update.
  always_comb begin
    acc_d    = acc_q;
    sticky_d = sticky_q;
    if (clear) begin
      acc_d    = '0;
      sticky_d = 1'b0;
    end else if (advance) begin
      acc_d    = core_sum;
      sticky_d = sticky_q | carry_evt;
    end
  end

  // Accumulator and sticky registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      sticky_q <= sticky_d;
    end
  end

  assign out_carry_sticky = sticky_q;

endmodule

// File: tb/tb_add64_accum_pipe.sv
// Scoreboard bench for add64_accum_pipe. Expected results come from a behavioural model
// evaluated at each input transfer and are compared in order at each output transfer.
module tb_add64_accum_pipe;

  localparam int unsigned N = 64;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic         in_cin;
  logic         in_acc;
`ifdef ADD64_PIPE_SUB_EN
  logic         in_sub;
`endif
  logic         clear;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_sum;
  logic         out_cout;
  logic         out_carry_sticky;

  add64_accum_pipe #(
    .N(N)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_a            (in_a),
    .in_b            (in_b),
    .in_cin          (in_cin),
    .in_acc          (in_acc),
`ifdef ADD64_PIPE_SUB_EN
    .in_sub          (in_sub),
`endif
    .clear           (clear),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_sum         (out_sum),
    .out_cout        (out_cout),
    .out_carry_sticky(out_carry_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] sum;
    logic         cout;
    logic         sticky;
  } exp_t;

  exp_t         sb_q[$];
  logic [N-1:0] acc_m;
  logic         sticky_m;
  int           n_cmp;
  int           n_err;
  int           stall_cnt;
  int           acc_cnt;
  int           first_stall_acc;

  task automatic check_val(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp_v);
    end
  endtask

  // Reference model evaluated at the input transfer; beats complete in order.
  task automatic model_push(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin,
                            input logic acc, input logic sub);
    logic [N:0]   full;
    logic [N-1:0] ae, bb;
    logic         ci;
    exp_t         e;
    ae   = acc ? acc_m : a;
    bb   = sub ? ~b : b;
    ci   = sub ? 1'b1 : cin;
    full = {1'b0, ae} + {1'b0, bb} + {{N{1'b0}}, ci};
    acc_m    = full[N-1:0];
    sticky_m = sticky_m | (sub ? ~full[N] : full[N]);
    e.sum    = full[N-1:0];
    e.cout   = full[N];
    e.sticky = sticky_m;
    sb_q.push_back(e);
  endtask

  // Called at a falling edge; returns at the falling edge after the transfer, in_valid left high.
  task automatic drive_beat(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin,
                            input logic acc, input logic sub);
    int waited;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_acc   = acc;
`ifdef ADD64_PIPE_SUB_EN
    in_sub   = sub;
`endif
    in_valid = 1'b1;
    waited   = 0;
    #1;
    while (!in_ready) begin
      stall_cnt++;
      if (first_stall_acc < 0) first_stall_acc = acc_cnt;
      if (waited > 50) begin
        check_val("in_ready_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
      #1;
      waited++;
    end
    model_push(a, b, cin, acc, sub);
    acc_cnt++;
    @(negedge clk);
  endtask

  task automatic wait_drain();
    int budget;
    budget = 0;
    while (sb_q.size() != 0 && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    if (sb_q.size() != 0) check_val("drain_timeout", 64'(sb_q.size()), 0);
    @(negedge clk);
  endtask

  // Output monitor: compare at every output transfer, sampled mid low phase.
  always begin
    @(negedge clk);
    #2;
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check_val("unexpected_out", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_val("out_sum", out_sum, e.sum);
        check_val("out_cout", 64'(out_cout), 64'(e.cout));
        check_val("out_sticky", 64'(out_carry_sticky), 64'(e.sticky));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_err = 0; stall_cnt = 0; acc_cnt = 0; first_stall_acc = -1;
    acc_m = '0; sticky_m = 1'b0;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_acc = 1'b0;
`ifdef ADD64_PIPE_SUB_EN
    in_sub = 1'b0;
`endif
    clear = 1'b0; out_ready = 1'b1;

    // Reset state
    #1;
    check_val("rst_out_valid", 64'(out_valid), 0);
    check_val("rst_out_sum", out_sum, 0);
    check_val("rst_out_cout", 64'(out_cout), 0);
    check_val("rst_sticky", 64'(out_carry_sticky), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check_val("rst_in_ready", 64'(in_ready), 1);
    @(negedge clk);

    // Single beat with latency check: 5 + 7
    drive_beat(64'd5, 64'd7, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    #1;
    check_val("lat_cycle1_valid", 64'(out_valid), 0);
    @(negedge clk);
    #1;
    check_val("lat_cycle2_valid", 64'(out_valid), 1);
    @(negedge clk);
    wait_drain();

    // Wrap-around, then clear of the sticky flag
    drive_beat({N{1'b1}}, 64'd1, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    wait_drain();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    #1;
    check_val("clear_sticky", 64'(out_carry_sticky), 0);
    check_val("clear_acc", dut.acc_q, 0);
    acc_m = '0; sticky_m = 1'b0;
    @(negedge clk);

    // Back-to-back accumulate run: 13, 14, 15, 16
    stall_cnt = 0;
    drive_beat(64'd10, 64'd3, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive_beat(64'd0, 64'd1, 1'b0, 1'b1, 1'b0);
    in_valid = 1'b0;
    check_val("acc_run_stalls", 64'(stall_cnt), 0);
    wait_drain();

    // Back-pressure: 4 beats, out_ready low for 5 cycles
    out_ready = 1'b0; acc_cnt = 0; first_stall_acc = -1;
    fork
      begin
        for (int i = 1; i <= 4; i++) drive_beat(64'd0, 64'(i), 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
      end
      begin
        repeat (5) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    check_val("bp_accepted_before_stall", 64'(first_stall_acc), 2);
    wait_drain();

    // Clear on the same edge as a stage-2 advance: sum passes, acc and sticky cleared
    drive_beat({N{1'b1}}, 64'd3, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    clear    = 1'b1;
    sb_q[sb_q.size()-1].sticky = 1'b0;
    acc_m = '0; sticky_m = 1'b0;
    @(negedge clk);
    clear = 1'b0;
    drive_beat(64'd0, 64'd5, 1'b0, 1'b1, 1'b0);
    in_valid = 1'b0;
    wait_drain();

    // Reset while both stages are full
    out_ready = 1'b0;
    drive_beat(64'd0, 64'd9, 1'b0, 1'b0, 1'b0);
    drive_beat(64'd0, 64'd8, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    #1;
    check_val("mid_full_valid", 64'(out_valid), 1);
    #1;
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_valid", 64'(out_valid), 0);
    check_val("mid_rst_acc", dut.acc_q, 0);
    check_val("mid_rst_sum", out_sum, 0);
    sb_q.delete();
    acc_m = '0; sticky_m = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    drive_beat(64'd2, 64'd2, 1'b0, 1'b1, 1'b0);
    in_valid = 1'b0;
    wait_drain();

`ifdef ADD64_PIPE_SUB_EN
    // Subtract: borrow sets sticky; cin ignored
    drive_beat(64'd3, 64'd5, 1'b1, 1'b0, 1'b1);
    drive_beat(64'd5, 64'd3, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b0;
    wait_drain();
`endif

    check_val("sb_empty", 64'(sb_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
